nor_func_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the 4-input NOR-only function block F = w~x + ~w~z + ~y~z.
//  - On start, drives all 16 input vectors {w,x,y,z} into the block, one at a time.
//  - Samples F for each vector and compares it against a golden truth table.
//  - Reports pass/fail, error count, first failing vector and the captured response map.
//  - Sits beside the function block and replaces the free-running exhaustive testbench with on-chip BIST.

---
 rtl/nor_func_sweep_ctrl_pkg.sv | 22 ++
 rtl/sweep_settle_timer.sv | 33 +++
 rtl/nor_func_sweep_ctrl.sv | 170 +++++++++++++++++
 tb/tb_nor_func_sweep_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_func_sweep_ctrl_pkg.sv
// Shared types and constants for the NOR function-block self-test sequencer.
// Holds the state encoding, the golden truth table and the datapath widths.
package nor_func_sweep_ctrl_pkg;

  localparam int unsigned VEC_W = 4;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned ERR_W = 5;
  localparam int unsigned CNT_W = 8;

  // F = w~x + ~w~z + ~y~z, bit i = F at index {w,x,y,z}
  localparam logic [NUM_VEC-1:0] NOR_F_GOLDEN = 16'h1F55;

  localparam logic [VEC_W-1:0] VEC_LAST = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that times how long each vector settles before F is sampled.
// The zero flag is registered alongside the count so it is valid in the cycle after a load.
module sweep_settle_timer
  import nor_func_sweep_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;

  // Load has priority over decrement; the count parks at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else if (load_i) begin
      cnt_q  <= load_val_i;
      zero_q <= (load_val_i == '0);
    end else if (dec_i && !zero_q) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      zero_q <= (cnt_q == CNT_W'(1));
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/nor_func_sweep_ctrl.sv
// On-chip BIST sequencer: sweeps all 16 {w,x,y,z} vectors into the NOR function block,
// compares each sampled F against the golden table and reports pass/fail and debug state.
module nor_func_sweep_ctrl
  import nor_func_sweep_ctrl_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] GOLDEN     = NOR_F_GOLDEN,
  parameter int unsigned        SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [VEC_W-1:0]   dut_vec,
  input  logic               dut_f,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               pass,
  output logic [ERR_W-1:0]   err_cnt,
  output logic               first_fail_vld,
  output logic [VEC_W-1:0]   first_fail_idx,
  output logic [NUM_VEC-1:0] result_map
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  sweep_state_e       state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               aborted_q, aborted_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               ffv_q, ffv_d;
  logic [VEC_W-1:0]   ffi_q, ffi_d;
  logic [NUM_VEC-1:0] map_q, map_d;

  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;

  sweep_settle_timer u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ffv_q     <= 1'b0;
      ffi_q     <= '0;
      map_q     <= '0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffi_q     <= ffi_d;
      map_q     <= map_d;
    end
  end

  // Next-state, vector stepping and scoreboard; abort skips the sample in flight.
  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffi_d     = ffi_q;
    map_d     = map_q;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_SETTLE;
          busy_d   = 1'b1;
          vec_d    = '0;
          pass_d   = 1'b0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffi_d    = '0;
          map_d    = '0;
          tmr_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          vec_d     = '0;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          vec_d     = '0;
          aborted_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          map_d[vec_q] = dut_f;
          if (dut_f != GOLDEN[vec_q]) begin
            err_d = err_q + ERR_W'(1);
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = vec_q;
            end
          end
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
          end else begin
            vec_d    = vec_q + VEC_W'(1);
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dut_vec        = vec_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
  assign result_map     = map_q;

endmodule

// File: tb/tb_nor_func_sweep_ctrl.sv
// Self-checking bench for nor_func_sweep_ctrl with a behavioural function-block model
// that can be correct, stuck-at-0, stuck-at-1 or corrupted at a couple of vectors.
module tb_nor_func_sweep_ctrl;

  typedef struct {
    logic [4:0]  err;
    logic        pass;
    logic        vld;
    logic [3:0]  idx;
    logic [15:0] map;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [3:0]  dut_vec;
  logic        dut_f;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        pass;
  logic [4:0]  err_cnt;
  logic        first_fail_vld;
  logic [3:0]  first_fail_idx;
  logic [15:0] result_map;

  int   mode;
  int   errors;
  int   checks;
  exp_t exp_q[$];

  nor_func_sweep_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .dut_vec        (dut_vec),
    .dut_f          (dut_f),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_idx (first_fail_idx),
    .result_map     (result_map)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f_ref(input logic [3:0] v);
    return (v[3] & ~v[2]) | (~v[3] & ~v[0]) | (~v[1] & ~v[0]);
  endfunction

  // 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 flipped at vectors 10 and 12
  function automatic logic f_blk(input int m, input logic [3:0] v);
    case (m)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return f_ref(v) ^ ((v == 4'd10) || (v == 4'd12));
      default: return f_ref(v);
    endcase
  endfunction

  assign dut_f = f_blk(mode, dut_vec);

  function automatic exp_t build_exp(input int m, input int nvec);
    exp_t e;
    logic b;
    e.err = '0; e.vld = 1'b0; e.idx = '0; e.map = '0;
    for (int i = 0; i < nvec; i++) begin
      b = f_blk(m, 4'(i));
      e.map[i] = b;
      if (b !== f_ref(4'(i))) begin
        e.err = e.err + 5'd1;
        if (!e.vld) begin
          e.vld = 1'b1;
          e.idx = 4'(i);
        end
      end
    end
    e.pass = (e.err == 5'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input int m, input bit repulse, input bit abort_done, input string tag);
    exp_t e;
    bit   seen;
    int   done_k;
    mode = m;
    exp_q.push_back(build_exp(m, 16));
    seen = 1'b0;
    done_k = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (k <= 47) begin
        checks++;
        if (dut_vec !== 4'(k / 3))
          $display("FAIL %s vec k=%0d: got %0d want %0d", tag, k, dut_vec, k / 3);
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        done_k = k;
        break;
      end
      checks++;
      if (busy !== 1'b1 || aborted !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/aborted k=%0d: got %b/%b want 1/0", tag, k, busy, aborted);
      end
      start = repulse && (k == 9 || k == 28);
      abort = abort_done && (k == 48);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!seen || done_k != 49) begin
      errors++;
      $display("FAIL %s latency: got %0d want 49", tag, done_k);
    end else begin
      checks++;
      if (err_cnt !== e.err || pass !== e.pass || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s err/pass/busy: got %0d/%b/%b want %0d/%b/0", tag, err_cnt, pass, busy, e.err, e.pass);
      end
      checks++;
      if (first_fail_vld !== e.vld || (e.vld && first_fail_idx !== e.idx)) begin
        errors++;
        $display("FAIL %s first_fail: got %b/%0d want %b/%0d", tag, first_fail_vld, first_fail_idx, e.vld, e.idx);
      end
      checks++;
      if (result_map !== e.map) begin
        errors++;
        $display("FAIL %s result_map: got %h want %h", tag, result_map, e.map);
      end
      tick();
      checks++;
      if (done !== 1'b0 || err_cnt !== e.err || result_map !== e.map || pass !== e.pass) begin
        errors++;
        $display("FAIL %s hold: done=%b err=%0d map=%h pass=%b want 0/%0d/%h/%b", tag, done, err_cnt, result_map, pass, e.err, e.map, e.pass);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({dut_vec, busy, done, aborted, pass, err_cnt, first_fail_vld, first_fail_idx, result_map} !== '0) begin
      errors++;
      $display("FAIL reset outputs: vec=%h busy=%b done=%b ab=%b pass=%b err=%0d vld=%b idx=%0d map=%h want all 0",
               dut_vec, busy, done, aborted, pass, err_cnt, first_fail_vld, first_fail_idx, result_map);
    end
  endtask

  task automatic test_faults();
    run_sweep(1, 1'b0, 1'b0, "stuck0");
    run_sweep(2, 1'b0, 1'b0, "stuck1");
    run_sweep(3, 1'b0, 1'b0, "flip10_12");
  endtask

  task automatic test_abort();
    exp_t e;
    int   n;
    bit   saw_done;
    mode = 1;
    e = build_exp(1, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (dut_vec !== 4'd5 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL abort wait_vec5: got %0d want 5", dut_vec);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b1 || dut_vec !== 4'd0 || done !== 1'b0 || pass !== 1'b0) begin
      errors++;
      $display("FAIL abort flags: busy=%b ab=%b vec=%0d done=%b pass=%b want 0/1/0/0/0", busy, aborted, dut_vec, done, pass);
    end
    checks++;
    if (err_cnt !== e.err || result_map !== e.map || first_fail_vld !== e.vld || first_fail_idx !== e.idx) begin
      errors++;
      $display("FAIL abort partial: err=%0d map=%h vld=%b idx=%0d want %0d/%h/%b/%0d",
               err_cnt, result_map, first_fail_vld, first_fail_idx, e.err, e.map, e.vld, e.idx);
    end
    tick();
    checks++;
    if (aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort pulse_width: got %b want 0", aborted);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      tick();
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort no_done: got 1 want 0");
    end
    run_sweep(0, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_abort_start_idle();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || aborted !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle: busy=%b ab=%b want 0/0", busy, aborted);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_start_idle later: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    run_sweep(0, 1'b1, 1'b0, "restart_ignored");
    run_sweep(0, 1'b0, 1'b1, "abort_in_done");
  endtask

  task automatic test_reset_mid();
    int n;
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (dut_vec !== 4'd7 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL rst_mid wait_vec7: got %0d want 7", dut_vec);
    end
    #1 rst_n = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || dut_vec !== 4'd0) begin
      errors++;
      $display("FAIL rst_mid after_release: busy=%b done=%b ab=%b vec=%0d want 0/0/0/0", busy, done, aborted, dut_vec);
    end
    run_sweep(0, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mode   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    #3;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_reset();
    run_sweep(0, 1'b0, 1'b0, "clean");
    test_faults();
    test_abort();
    test_abort_start_idle();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
